// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU for the RISC-V execute stage.
//
// Ops 0000-1011 (add, sub, not, shifts, logic, compares, pass-b) finish in
// one cycle. Ops 1100-1111 (MUL, MULHU, DIVU, REMU) run for WIDTH cycles.
// MUL and MULHU use a shift-add multiplier. DIVU and REMU use a restoring
// divider. Both produce one bit per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort of any op in flight or held
//   in_valid     operands/op presented
//   in_ready     unit idle, can accept an op
//   a, b         source operands (WIDTH bits)
//   alu_control  4-bit function select
//   out_valid    result available
//   out_ready    consumer takes result
//   result       registered result (WIDTH bits)
//   zero         result == 0, registered alongside result
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [SHW-1:0]     cnt_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] mul_acc_reg;
    logic [WIDTH-1:0]   div_rem_reg;
    logic [WIDTH-1:0]   div_quo_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;

    logic               accept;
    logic               iterative;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_out;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   iter_out;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;

    // flush is handled in the register process. It blocks acceptance.
    assign accept    = in_valid && (state_reg == IDLE);
    assign iterative = alu_control[3] & alu_control[2];
    assign shamt     = b[SHW-1:0];

    // Single-cycle function unit. It works on the live operands, because its
    // result is loaded in the cycle the op is accepted.
    always_comb begin
        alu_out = '0;
        case (alu_control)
            4'b0000: alu_out = a + b;
            4'b0001: alu_out = a - b;
            4'b0010: alu_out = ~a;
            4'b0011: alu_out = a << shamt;
            4'b0100: alu_out = a >> shamt;
            4'b0101: alu_out = a & b;
            4'b0110: alu_out = a | b;
            4'b0111: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1000: alu_out = b;
            4'b1001: alu_out = a ^ b;
            4'b1010: alu_out = $signed(a) >>> shamt;
            4'b1011: alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_out = '0;
        endcase
    end

    // Shift-add multiplier step. The multiplier occupies the low half of the
    // accumulator. Each step adds the multiplicand to the high half when the
    // current LSB is set, then shifts everything right by one. The carry bit
    // enters the top of the accumulator.
    assign mul_sum  = {1'b0, mul_acc_reg[2*WIDTH-1:WIDTH]}
                    + (mul_acc_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, mul_acc_reg[WIDTH-1:1]};

    // Restoring divider step. The dividend bits shift out of the quotient
    // register into the partial remainder. An explicit compare is used
    // instead of the sign of the difference, so that a zero divisor gives an
    // all-ones quotient and leaves the dividend in the remainder.
    assign div_shift = {div_rem_reg, div_quo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {div_quo_reg[WIDTH-2:0], div_ge};

    // The final iteration and the result load happen on the same edge.
    // So the result is taken from the step outputs, not from the registers.
    always_comb begin
        iter_out = '0;
        case (op_reg)
            2'b00:   iter_out = mul_next[WIDTH-1:0];
            2'b01:   iter_out = mul_next[2*WIDTH-1:WIDTH];
            2'b10:   iter_out = quo_next;
            default: iter_out = rem_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = iterative ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mul_acc_reg <= '0;
            div_rem_reg <= '0;
            div_quo_reg <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
        end else if (!flush) begin
            if (accept) begin
                op_reg      <= alu_control[1:0];
                a_reg       <= a;
                b_reg       <= b;
                mul_acc_reg <= {{WIDTH{1'b0}}, b};
                div_rem_reg <= '0;
                div_quo_reg <= a;
                cnt_reg     <= CNT_INIT;
                if (!iterative) begin
                    result_reg <= alu_out;
                    zero_reg   <= (alu_out == '0);
                end
            end else if (state_reg == BUSY) begin
                mul_acc_reg <= mul_next;
                div_rem_reg <= rem_next;
                div_quo_reg <= quo_next;
                if (cnt_reg == '0) begin
                    result_reg <= iter_out;
                    zero_reg   <= (iter_out == '0);
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc (WIDTH = 32).
// Inputs are driven on the falling edge and outputs are sampled there.
// Latency is counted in cycles after acceptance.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  alu_control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;

    vec_t single_tbl [14] = '{
        '{4'h0, 32'd5,         32'd7,         32'd12},
        '{4'h1, 32'd3,         32'd5,         32'hFFFF_FFFE},
        '{4'hB, 32'hFFFF_FFFF, 32'd1,         32'd1},
        '{4'hA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
        '{4'h3, 32'd1,         32'd31,        32'h8000_0000},
        '{4'h7, 32'hFFFF_FFFF, 32'd1,         32'd0},
        '{4'h2, 32'h0F0F_00FF, 32'd0,         32'hF0F0_FF00},
        '{4'h4, 32'h8000_0000, 32'h0000_003F, 32'd1},
        '{4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{4'h6, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
        '{4'h9, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
        '{4'h8, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0},
        '{4'h1, 32'd7,         32'd7,         32'd0},
        '{4'hB, 32'd1,         32'hFFFF_FFFF, 32'd0}
    };

    vec_t iter_tbl [11] = '{
        '{4'hC, 32'h0001_0000, 32'h0001_0000, 32'd0},
        '{4'hD, 32'h0001_0000, 32'h0001_0000, 32'd1},
        '{4'hE, 32'd100,       32'd7,         32'd14},
        '{4'hF, 32'd100,       32'd7,         32'd2},
        '{4'hE, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{4'hF, 32'd5,         32'd0,         32'd5},
        '{4'hC, 32'd7,         32'd9,         32'd63},
        '{4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1},
        '{4'hE, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF},
        '{4'hF, 32'hFFFF_FFFF, 32'd16,        32'd15}
    };

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // Presents one op with out_ready high and waits for its result.
    // The wait is bounded to 100 cycles. The operands are cleared after
    // acceptance. Only observations are returned; the callers do the checks.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output logic [31:0] res, output logic z,
                         output logic acc_ok, output logic busy_ok, output logic idle_after);
        @(negedge clk);
        alu_control = op;
        a           = av;
        b           = bv;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        acc_ok      = (in_ready === 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        lat      = 1;
        busy_ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        res = result;
        z   = zero;
        @(negedge clk);
        idle_after = (in_ready === 1'b1) && (out_valid === 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_vec++;
        if (result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_result got=%h want=00000000", result);
        end
        n_vec++;
        if (zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_zero got=%b want=1", zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        $display("reset: out_valid=%b result=%h zero=%b in_ready=%b", out_valid, result, zero, in_ready);
    endtask

    task automatic run_table_entry(input vec_t v, input int want_lat, input string tag);
        int          lat;
        logic [31:0] res;
        logic        z, acc_ok, busy_ok, idle_after;
        issue(v.op, v.a, v.b, lat, res, z, acc_ok, busy_ok, idle_after);
        $display("%s op=%h a=%h b=%h -> result=%h zero=%b lat=%0d", tag, v.op, v.a, v.b, res, z, lat);
        n_vec++;
        if (res !== v.exp) begin
            n_err++;
            $display("FAIL %s_result op=%h got=%h want=%h", tag, v.op, res, v.exp);
        end
        n_vec++;
        if (z !== (v.exp == 32'd0)) begin
            n_err++;
            $display("FAIL %s_zero op=%h got=%b want=%b", tag, v.op, z, (v.exp == 32'd0));
        end
        n_vec++;
        if (lat != want_lat) begin
            n_err++;
            $display("FAIL %s_latency op=%h got=%0d want=%0d", tag, v.op, lat, want_lat);
        end
        n_vec++;
        if (!(acc_ok && busy_ok && idle_after)) begin
            n_err++;
            $display("FAIL %s_ready op=%h got=%b%b%b want=111", tag, v.op, acc_ok, busy_ok, idle_after);
        end
    endtask

    task automatic test_single;
        for (int i = 0; i < 14; i++) run_table_entry(single_tbl[i], 1, "single");
    endtask

    task automatic test_iterative;
        for (int i = 0; i < 11; i++) run_table_entry(iter_tbl[i], W + 1, "iter");
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        int dones   = 0;
        logic res_ok = 1'b1;
        @(negedge clk);
        alu_control = 4'h0;
        a           = 32'd10;
        b           = 32'd1;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in_ready === 1'b1) accepts++;
            if (out_valid === 1'b1) begin
                dones++;
                if (result !== 32'd11) res_ok = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        $display("b2b: accepts=%0d dones=%0d", accepts, dones);
        n_vec++;
        if (accepts != 4) begin
            n_err++;
            $display("FAIL b2b_accepts got=%0d want=4", accepts);
        end
        n_vec++;
        if (dones != 4 || !res_ok) begin
            n_err++;
            $display("FAIL b2b_results got=%0d ok=%b want=4 ok=1", dones, res_ok);
        end
    endtask

    task automatic test_backpressure;
        logic stable_ok = 1'b1;
        @(negedge clk);
        alu_control = 4'h0;
        a           = 32'd1;
        b           = 32'd2;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        @(negedge clk);
        alu_control = 4'h8;
        a           = 32'd100;
        b           = 32'd100;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            if (out_valid !== 1'b1 || result !== 32'd3 || zero !== 1'b0 || in_ready !== 1'b0)
                stable_ok = 1'b0;
            @(negedge clk);
        end
        $display("backpressure: held result=%h out_valid=%b in_ready=%b", result, out_valid, in_ready);
        n_vec++;
        if (!stable_ok) begin
            n_err++;
            $display("FAIL bp_hold got=unstable want=stable result 00000003");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got=ov%b ir%b want=ov0 ir1", out_valid, in_ready);
        end
        n_vec++;
        if (result !== 32'd3) begin
            n_err++;
            $display("FAIL bp_result_kept got=%h want=00000003", result);
        end
    endtask

    task automatic test_flush;
        logic        never_valid = 1'b1;
        int          lat;
        logic [31:0] res;
        logic        z, acc_ok, busy_ok, idle_after;
        @(negedge clk);
        alu_control = 4'hE;
        a           = 32'd100;
        b           = 32'd7;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle got=ir%b ov%b want=ir1 ov0", in_ready, out_valid);
        end
        n_vec++;
        if (result !== 32'd3) begin
            n_err++;
            $display("FAIL flush_result_kept got=%h want=00000003", result);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) never_valid = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (!never_valid) begin
            n_err++;
            $display("FAIL flush_no_result got=out_valid seen want=none");
        end
        issue(4'h0, 32'd2, 32'd2, lat, res, z, acc_ok, busy_ok, idle_after);
        $display("flush: next ADD result=%h lat=%0d", res, lat);
        n_vec++;
        if (res !== 32'd4 || lat != 1) begin
            n_err++;
            $display("FAIL flush_next_op got=%h lat=%0d want=00000004 lat=1", res, lat);
        end
        // An op presented together with flush is dropped.
        @(negedge clk);
        alu_control = 4'h0;
        a           = 32'd1;
        b           = 32'd1;
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd4) begin
            n_err++;
            $display("FAIL flush_blocks_accept got=ov%b ir%b res=%h want=ov0 ir1 res=00000004",
                     out_valid, in_ready, result);
        end
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic [31:0] res;
        logic        z, acc_ok, busy_ok, idle_after;
        @(negedge clk);
        alu_control = 4'hD;
        a           = 32'h0001_0000;
        b           = 32'h0001_0000;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset_mid: in_ready=%b out_valid=%b result=%h zero=%b", in_ready, out_valid, result, zero);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_handshake got=ir%b ov%b want=ir1 ov0", in_ready, out_valid);
        end
        n_vec++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_result got=%h z=%b want=00000000 z=1", result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'h1, 32'd10, 32'd3, lat, res, z, acc_ok, busy_ok, idle_after);
        $display("reset_mid: SUB result=%h lat=%0d", res, lat);
        n_vec++;
        if (res !== 32'd7 || lat != 1 || !acc_ok) begin
            n_err++;
            $display("FAIL rstmid_sub got=%h lat=%0d want=00000007 lat=1", res, lat);
        end
        issue(4'hD, 32'h0001_0000, 32'h0001_0000, lat, res, z, acc_ok, busy_ok, idle_after);
        $display("reset_mid: MULHU result=%h lat=%0d", res, lat);
        n_vec++;
        if (res !== 32'd1 || lat != W + 1) begin
            n_err++;
            $display("FAIL rstmid_mulhu got=%h lat=%0d want=00000001 lat=%0d", res, lat, W + 1);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_iterative;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=no finish want=finish");
        $fatal(1, "timeout");
    end

endmodule
